// File: rtl/minimig_zorro_access_ctrl.sv
// Sequences CPU accesses to the autoconfigured Zorro II boards (Toccata, control board).
// Define MINIMIG_ZORRO_TIMEOUT_COUNT_EN to add the saturating timeout_count output.
module minimig_zorro_access_ctrl #(
    parameter logic        TOCCATA_SND   = 1'b0,
    parameter logic        CONTROL_BOARD = 1'b0,
    parameter int unsigned TIMEOUT_TICKS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk7_en,
    input  logic [23:1] cpu_address_in,
    input  logic        cpu_as,
    input  logic        cpu_rd,
    input  logic        cpu_hwr,
    input  logic        cpu_lwr,
    output logic [15:0] cpu_data_out,
    output logic        cpu_ack,
    input  logic [5:0]  board_configured,
    input  logic [5:0]  board_shutup,
    input  logic [7:0]  toccata_base_addr,
    input  logic [7:0]  control_base_addr,
    output logic        toccata_req,
    input  logic        toccata_ack,
    input  logic [15:0] toccata_data_in,
    output logic        control_req,
    input  logic        control_ack,
    input  logic [15:0] control_data_in,
    output logic [1:0]  board_we,
`ifdef MINIMIG_ZORRO_TIMEOUT_COUNT_EN
    output logic [7:0]  timeout_count,
`endif
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_TICKS - 1);

    state_t      state_q;
    logic [7:0]  cnt_q;
    logic        sel_toc_q;
    logic        rd_q;
    logic        cpu_ack_q;
    logic [15:0] data_q;
    logic        toc_req_q;
    logic        ctl_req_q;
    logic [1:0]  we_q;
    logic        terr_q;
`ifdef MINIMIG_ZORRO_TIMEOUT_COUNT_EN
    logic [7:0]  tcount_q;
`endif

    logic        toc_hit;
    logic        ctl_hit;
    logic        access_valid;
    logic        sel_ack;
    logic [15:0] sel_data;
    logic        unused_addr;

    assign toc_hit = TOCCATA_SND & board_configured[4] & ~board_shutup[4]
                   & (cpu_address_in[23:16] == toccata_base_addr);
    assign ctl_hit = CONTROL_BOARD & board_configured[5] & ~board_shutup[5]
                   & (cpu_address_in[23:16] == control_base_addr);
    assign access_valid = cpu_as & (cpu_rd | cpu_hwr | cpu_lwr);
    // Only the board that was selected at decode time may end the access.
    assign sel_ack  = sel_toc_q ? toccata_ack : control_ack;
    assign sel_data = sel_toc_q ? toccata_data_in : control_data_in;
    assign unused_addr = &{1'b0, cpu_address_in[15:1], board_configured[3:0], board_shutup[3:0]};

    // Access sequencer: decode, board handshake with timeout, CPU response.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 8'd0;
            sel_toc_q <= 1'b0;
            rd_q      <= 1'b0;
            cpu_ack_q <= 1'b0;
            data_q    <= 16'h0000;
            toc_req_q <= 1'b0;
            ctl_req_q <= 1'b0;
            we_q      <= 2'b00;
            terr_q    <= 1'b0;
`ifdef MINIMIG_ZORRO_TIMEOUT_COUNT_EN
            tcount_q  <= 8'd0;
`endif
        end else begin
            terr_q <= 1'b0;
            if (clk7_en) begin
                case (state_q)
                    ST_IDLE: begin
                        if (access_valid) begin
                            rd_q <= cpu_rd;
                            if (toc_hit || ctl_hit) begin
                                sel_toc_q <= toc_hit;
                                toc_req_q <= toc_hit;
                                ctl_req_q <= ~toc_hit;
                                we_q      <= {cpu_hwr, cpu_lwr};
                                cnt_q     <= 8'd0;
                                state_q   <= ST_ACCESS;
                            end else begin
                                data_q  <= 16'hFFFF;
                                state_q <= ST_RESP;
                            end
                        end
                    end
                    ST_ACCESS: begin
                        if (sel_ack) begin
                            data_q    <= rd_q ? sel_data : 16'h0000;
                            toc_req_q <= 1'b0;
                            ctl_req_q <= 1'b0;
                            state_q   <= ST_RESP;
                        end else if (cnt_q == TO_LAST) begin
                            data_q    <= 16'hFFFF;
                            toc_req_q <= 1'b0;
                            ctl_req_q <= 1'b0;
                            terr_q    <= 1'b1;
`ifdef MINIMIG_ZORRO_TIMEOUT_COUNT_EN
                            if (tcount_q != 8'hFF) begin
                                tcount_q <= tcount_q + 8'd1;
                            end
`endif
                            state_q   <= ST_RESP;
                        end else begin
                            cnt_q <= cnt_q + 8'd1;
                        end
                    end
                    ST_RESP: begin
                        // An access abandoned by the CPU leaves after one tick without acking.
                        if (!cpu_as) begin
                            cpu_ack_q <= 1'b0;
                            we_q      <= 2'b00;
                            state_q   <= ST_IDLE;
                        end else begin
                            cpu_ack_q <= 1'b1;
                        end
                    end
                    default: begin
                        toc_req_q <= 1'b0;
                        ctl_req_q <= 1'b0;
                        cpu_ack_q <= 1'b0;
                        state_q   <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign cpu_ack      = cpu_ack_q;
    assign cpu_data_out = data_q;
    assign toccata_req  = toc_req_q;
    assign control_req  = ctl_req_q;
    assign board_we     = we_q;
    assign timeout_err  = terr_q;
`ifdef MINIMIG_ZORRO_TIMEOUT_COUNT_EN
    assign timeout_count = tcount_q;
`endif

endmodule

// File: tb/tb_minimig_zorro_access_ctrl.sv
// Scoreboard bench for minimig_zorro_access_ctrl: directed accesses, board responder models.
module tb_minimig_zorro_access_ctrl;

    logic        clk;
    logic        reset;
    logic        clk7_en;
    logic [23:1] cpu_address_in;
    logic        cpu_as, cpu_rd, cpu_hwr, cpu_lwr;
    logic [15:0] cpu_data_out;
    logic        cpu_ack;
    logic [5:0]  board_configured, board_shutup;
    logic [7:0]  toccata_base_addr, control_base_addr;
    logic        toccata_req, toccata_ack;
    logic [15:0] toccata_data_in;
    logic        control_req, control_ack;
    logic [15:0] control_data_in;
    logic [1:0]  board_we;
    logic        timeout_err;
`ifdef MINIMIG_ZORRO_TIMEOUT_COUNT_EN
    logic [7:0]  timeout_count;
`endif

    minimig_zorro_access_ctrl #(
        .TOCCATA_SND(1'b1), .CONTROL_BOARD(1'b1), .TIMEOUT_TICKS(64)
    ) dut (
        .clk(clk), .reset(reset), .clk7_en(clk7_en),
        .cpu_address_in(cpu_address_in), .cpu_as(cpu_as), .cpu_rd(cpu_rd),
        .cpu_hwr(cpu_hwr), .cpu_lwr(cpu_lwr), .cpu_data_out(cpu_data_out),
        .cpu_ack(cpu_ack), .board_configured(board_configured),
        .board_shutup(board_shutup), .toccata_base_addr(toccata_base_addr),
        .control_base_addr(control_base_addr), .toccata_req(toccata_req),
        .toccata_ack(toccata_ack), .toccata_data_in(toccata_data_in),
        .control_req(control_req), .control_ack(control_ack),
        .control_data_in(control_data_in), .board_we(board_we),
`ifdef MINIMIG_ZORRO_TIMEOUT_COUNT_EN
        .timeout_count(timeout_count),
`endif
        .timeout_err(timeout_err)
    );

    typedef struct {
        int data; int we; int terr; int toc_hi; int ctl_hi; int tcnt;
    } exp_t;
    exp_t sb_q[$];

    int checks = 0;
    int errors = 0;
    int tick_num = 0;
    int terr_seen = 0;
    int exp_tcnt = 0;
    int toc_delay = 0, toc_cnt = 0, toc_hi = 0;
    int ctl_delay = 0, ctl_cnt = 0, ctl_hi = 0;
    logic [15:0] toc_dat, ctl_dat;
    logic prev_ack = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        clk7_en = 1'b0;
        forever begin
            @(negedge clk);
            clk7_en = ~clk7_en;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Board responders and the scoreboard monitor, evaluated just after each clk edge.
    always @(posedge clk) begin
        bit was_tick;
        exp_t e;
        was_tick = clk7_en;
        #1;
        if (was_tick) tick_num++;
        if (timeout_err) terr_seen++;
        if (!toccata_req) begin
            toccata_ack = 1'b0; toc_cnt = 0;
        end else if (was_tick) begin
            toc_cnt++; toc_hi = toc_cnt;
            if (toc_cnt == toc_delay) begin toccata_ack = 1'b1; toccata_data_in = toc_dat; end
        end
        if (!control_req) begin
            control_ack = 1'b0; ctl_cnt = 0;
        end else if (was_tick) begin
            ctl_cnt++; ctl_hi = ctl_cnt;
            if (ctl_cnt == ctl_delay) begin control_ack = 1'b1; control_data_in = ctl_dat; end
        end
        if (cpu_ack && !prev_ack) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_ack", 1, 0);
            end else begin
                e = sb_q.pop_front();
                chk("data", int'(cpu_data_out), e.data);
                chk("board_we", int'(board_we), e.we);
                chk("timeout_pulses", terr_seen, e.terr);
                chk("toccata_req_ticks", toc_hi, e.toc_hi);
                chk("control_req_ticks", ctl_hi, e.ctl_hi);
`ifdef MINIMIG_ZORRO_TIMEOUT_COUNT_EN
                chk("timeout_count", int'(timeout_count), e.tcnt);
`endif
            end
        end
        prev_ack = cpu_ack;
    end

    task automatic access(input logic [23:0] addr, input logic rd, input logic hwr,
                          input logic lwr, input int tdly, input logic [15:0] tdat,
                          input int cdly, input logic [15:0] cdat, input int xdata,
                          input int xwe, input int xterr, input int xtoc, input int xctl,
                          input int xlat);
        exp_t e;
        int t0, n;
        @(negedge clk);
        toc_delay = tdly; toc_dat = tdat; toc_hi = 0;
        ctl_delay = cdly; ctl_dat = cdat; ctl_hi = 0;
        terr_seen = 0;
        e.data = xdata; e.we = xwe; e.terr = xterr; e.toc_hi = xtoc; e.ctl_hi = xctl;
        e.tcnt = exp_tcnt;
        sb_q.push_back(e);
        cpu_address_in = addr[23:1];
        cpu_rd = rd; cpu_hwr = hwr; cpu_lwr = lwr; cpu_as = 1'b1;
        t0 = tick_num;
        n = 0;
        while (!cpu_ack && n < 2000) begin @(negedge clk); n++; end
        if (!cpu_ack) chk("ack_wait_expired", 0, 1);
        else chk("latency_ticks", tick_num - t0, xlat);
        cpu_as = 1'b0; cpu_rd = 1'b0; cpu_hwr = 1'b0; cpu_lwr = 1'b0;
        n = 0;
        while (cpu_ack && n < 50) begin @(negedge clk); n++; end
        chk("ack_release", int'(cpu_ack), 0);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        cpu_address_in = 23'd0;
        cpu_as = 1'b0; cpu_rd = 1'b0; cpu_hwr = 1'b0; cpu_lwr = 1'b0;
        board_configured = 6'b110000; board_shutup = 6'b000000;
        toccata_base_addr = 8'hE9; control_base_addr = 8'hEA;
        toccata_ack = 1'b0; control_ack = 1'b0;
        toccata_data_in = 16'h0000; control_data_in = 16'h0000;
        toc_dat = 16'h0000; ctl_dat = 16'h0000;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_cpu_ack", int'(cpu_ack), 0);
        chk("rst_data", int'(cpu_data_out), 16'h0000);
        chk("rst_toc_req", int'(toccata_req), 0);
        chk("rst_ctl_req", int'(control_req), 0);
        chk("rst_we", int'(board_we), 0);
        chk("rst_terr", int'(timeout_err), 0);
`ifdef MINIMIG_ZORRO_TIMEOUT_COUNT_EN
        chk("rst_tcount", int'(timeout_count), 0);
`endif
        //      addr          rd    hwr   lwr   tdly tdat      cdly cdat      data     we terr toc ctl lat
        access(24'hE90010, 1'b1, 1'b0, 1'b0, 3, 16'h1234, 0, 16'h0000, 16'h1234, 0, 0, 3, 0, 5);
        access(24'hEA0002, 1'b0, 1'b1, 1'b1, 0, 16'h0000, 1, 16'hBEEF, 16'h0000, 3, 0, 0, 1, 3);
        access(24'hE9FFFE, 1'b1, 1'b0, 1'b0, 1, 16'hABCD, 0, 16'h0000, 16'hABCD, 0, 0, 1, 0, 3);
        access(24'hEA0100, 1'b1, 1'b0, 1'b0, 0, 16'h0000, 2, 16'h5A5A, 16'h5A5A, 0, 0, 0, 2, 4);
        access(24'hE90020, 1'b0, 1'b0, 1'b1, 2, 16'hC3C3, 0, 16'h0000, 16'h0000, 1, 0, 2, 0, 4);
        access(24'hE80000, 1'b1, 1'b0, 1'b0, 1, 16'h1111, 1, 16'h2222, 16'hFFFF, 0, 0, 0, 0, 2);
        board_shutup = 6'b010000;
        access(24'hE90000, 1'b1, 1'b0, 1'b0, 1, 16'h1111, 0, 16'h0000, 16'hFFFF, 0, 0, 0, 0, 2);
        board_shutup = 6'b000000;
        board_configured = 6'b010000;
        access(24'hEA0000, 1'b1, 1'b0, 1'b0, 0, 16'h0000, 1, 16'h2222, 16'hFFFF, 0, 0, 0, 0, 2);
        board_configured = 6'b110000;
        exp_tcnt = 1;
        access(24'hE90004, 1'b1, 1'b0, 1'b0, 0, 16'h0000, 0, 16'h0000, 16'hFFFF, 0, 1, 64, 0, 66);
        control_base_addr = 8'hE9;
        access(24'hE90000, 1'b1, 1'b0, 1'b0, 2, 16'h1111, 1, 16'h2222, 16'h1111, 0, 0, 2, 0, 4);
        control_base_addr = 8'hEA;
        access(24'hE90008, 1'b1, 1'b0, 1'b0, 64, 16'h7777, 0, 16'h0000, 16'h7777, 0, 0, 64, 0, 66);

        // Reset while the Toccata access is outstanding.
        @(negedge clk);
        toc_delay = 0;
        cpu_address_in = 23'h748000;
        cpu_rd = 1'b1; cpu_as = 1'b1;
        repeat (10) @(negedge clk);
        chk("pre_reset_toc_req", int'(toccata_req), 1);
        reset = 1'b1;
        @(negedge clk);
        chk("reset_toc_req", int'(toccata_req), 0);
        chk("reset_cpu_ack", int'(cpu_ack), 0);
        reset = 1'b0; cpu_as = 1'b0; cpu_rd = 1'b0;
        exp_tcnt = 0;
        repeat (4) @(negedge clk);
        access(24'hE90002, 1'b1, 1'b0, 1'b0, 1, 16'h4242, 0, 16'h0000, 16'h4242, 0, 0, 1, 0, 3);

        chk("scoreboard_empty", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
